// File: rtl/anubis_key_schedule.sv
// Anubis-128 round-key generator (N=4, R=12).
// Runs one key-evolution step per clock, extracts a round key from each step
// into a 13-entry bank, and serves the bank by index in encrypt or decrypt order.
module anubis_key_schedule #(
    parameter int KEY_W      = 128,
    parameter int NUM_ROUNDS = 12,
    parameter int IDX_W      = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [KEY_W-1:0] key_in,
    input  logic             key_valid,
    output logic             key_ready,
    output logic             busy,
    output logic             keys_ok,
    input  logic             dec,
    input  logic [IDX_W-1:0] rk_idx,
    output logic [KEY_W-1:0] rk_out
);

    // Anubis involutive S-box, entry x at bits [2047-8x -: 8].
    localparam logic [2047:0] SBOX = {
        128'ha7d3e671d0ac4d793ac991fc1e4754bd, 128'h8ca57afb63b8ddd4e5b3c5bea9880ca2,
        128'h39df29da2ba8cb4c4b22aa244170a6f9, 128'h5ae2b0367de433ff6020088b5eab7f78,
        128'h7c2c57d2dc6d7e0d5394c32827065fad, 128'h675c55480e52ea425b5d305851593c4e,
        128'h388a7214e7c6de508e92d17793459ace, 128'h2d0362b6b9bf966b3f0712ae4034463e,
        128'hdbcfecccc1a1c0d61df4613b10d868a0, 128'hb10a696c49fa76c49e9b6e99c2b798bc,
        128'h8f851fb4f8112e00251c2a3d054f7bb2, 128'h3290af19a3f7739d1574eeca9f0f1b75,
        128'h86849c4a971a65f6ed09bb2683eb6f81, 128'h046a430117e187f58de3238044166621,
        128'hfed531d935180264f2f156cd82c8baf0, 128'hefe9e8fd89d7c7b5a42f95130bf3e037
    };

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_GEN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Bit position of matrix byte (row i, column j); byte 0 is the key MSB.
    function automatic int bp(input int i, input int j);
        return 127 - 8 * (4 * i + j);
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [10:0] base;
        base = 11'd2047 - {x, 3'b000};
        return SBOX[base -: 8];
    endfunction

    // Multiply by x in GF(2^8) modulo x^8+x^4+x^3+x^2+1.
    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1d : 8'h00);
    endfunction

    // Multiply by 08^j (j = 0..3) as 3j doublings.
    function automatic logic [7:0] mul_e(input logic [7:0] a, input int j);
        logic [7:0] res;
        res = a;
        for (int n = 0; n < 9; n++) res = (n < 3 * j) ? xt(res) : res;
        return res;
    endfunction

    function automatic logic [127:0] gamma(input logic [127:0] a);
        logic [127:0] b;
        b = '0;
        for (int n = 0; n < 16; n++) b[127 - 8 * n -: 8] = sbox(a[127 - 8 * n -: 8]);
        return b;
    endfunction

    // Row-wise product with had(01,02,04,06).
    function automatic logic [127:0] theta(input logic [127:0] a);
        logic [127:0] b;
        logic [7:0]   x;
        logic [7:0]   acc;
        logic [1:0]   kj;
        b = '0;
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 4; j++) begin
                acc = 8'h00;
                for (int k = 0; k < 4; k++) begin
                    x  = a[bp(i, k) -: 8];
                    kj = 2'(k ^ j);
                    case (kj)
                        2'd0:    acc = acc ^ x;
                        2'd1:    acc = acc ^ xt(x);
                        2'd2:    acc = acc ^ xt(xt(x));
                        default: acc = acc ^ xt(xt(x)) ^ xt(x);
                    endcase
                end
                b[bp(i, j) -: 8] = acc;
            end
        end
        return b;
    endfunction

    // Evolution: gamma, column rotation pi, theta, then add the row-0 constant.
    function automatic logic [127:0] psi(input logic [127:0] a, input logic [IDX_W-1:0] r);
        logic [127:0] g;
        logic [127:0] p;
        logic [127:0] t;
        g = gamma(a);
        p = '0;
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++) p[bp(i, j) -: 8] = g[bp((i - j + 4) % 4, j) -: 8];
        t = theta(p);
        for (int j = 0; j < 4; j++) t[bp(0, j) -: 8] = t[bp(0, j) -: 8] ^ sbox(8'({r, 2'(j)}));
        return t;
    endfunction

    // Extraction: gamma, Vandermonde column reduction (points 08^j, Horner form),
    // transpose, theta.
    function automatic logic [127:0] omega(input logic [127:0] a);
        logic [127:0] g;
        logic [127:0] t;
        logic [7:0]   acc;
        g = gamma(a);
        t = '0;
        for (int c = 0; c < 4; c++) begin
            for (int j = 0; j < 4; j++) begin
                acc = 8'h00;
                for (int i = 3; i >= 0; i--) acc = mul_e(acc, j) ^ g[bp(i, c) -: 8];
                t[bp(c, j) -: 8] = acc;
            end
        end
        return theta(t);
    endfunction

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   r_q, r_d;
    logic [KEY_W-1:0]   kappa_q, kappa_d;
    logic               key_ready_q, key_ready_d;
    logic               busy_q, busy_d;
    logic               keys_ok_q, keys_ok_d;
    logic [KEY_W-1:0]   rk_out_q, rk_out_d;
    logic [KEY_W-1:0]   bank_q [NUM_ROUNDS+1];
    logic               bank_we_s;
    logic [KEY_W-1:0]   psi_s;
    logic [KEY_W-1:0]   omega_s;
    logic [IDX_W-1:0]   rd_idx_s;

    // Single evolution and single extraction instance, both fed from kappa.
    always_comb begin
        psi_s   = psi(kappa_q, r_q);
        omega_s = omega(kappa_q);
    end

    // Control FSM: accept a key in IDLE/DONE, then 13 generation steps.
    always_comb begin
        state_d     = state_q;
        r_d         = r_q;
        kappa_d     = kappa_q;
        key_ready_d = key_ready_q;
        busy_d      = busy_q;
        keys_ok_d   = keys_ok_q;
        bank_we_s   = 1'b0;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (key_valid && key_ready_q) begin
                    state_d     = ST_GEN;
                    r_d         = '0;
                    kappa_d     = key_in;
                    keys_ok_d   = 1'b0;
                    busy_d      = 1'b1;
                    key_ready_d = 1'b0;
                end else begin
                    state_d = state_q;
                end
            end
            ST_GEN: begin
                bank_we_s = 1'b1;
                r_d       = r_q + IDX_W'(1);
                if (r_q < IDX_W'(NUM_ROUNDS)) begin
                    kappa_d = psi_s;
                end else begin
                    state_d     = ST_DONE;
                    keys_ok_d   = 1'b1;
                    busy_d      = 1'b0;
                    key_ready_d = 1'b1;
                end
            end
            default: begin
                state_d     = ST_IDLE;
                key_ready_d = 1'b1;
                busy_d      = 1'b0;
                keys_ok_d   = 1'b0;
            end
        endcase
    end

    // Read path: zero unless the bank is valid now and stays valid this edge.
    always_comb begin
        rk_out_d = '0;
        rd_idx_s = IDX_W'(NUM_ROUNDS) - rk_idx;
        if (!keys_ok_q || !keys_ok_d || (rk_idx > IDX_W'(NUM_ROUNDS))) begin
            rk_out_d = '0;
        end else if (!dec) begin
            rk_out_d = bank_q[rk_idx];
        end else if ((rk_idx == '0) || (rk_idx == IDX_W'(NUM_ROUNDS))) begin
            rk_out_d = bank_q[rd_idx_s];
        end else begin
            rk_out_d = theta(bank_q[rd_idx_s]);
        end
    end

    // Key bank: one extracted key per GEN cycle; qualified by keys_ok, so no reset.
    always_ff @(posedge clk) begin
        if (bank_we_s) begin
            bank_q[r_q] <= omega_s;
        end
    end

    // State, key and output registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            r_q         <= '0;
            kappa_q     <= '0;
            key_ready_q <= 1'b1;
            busy_q      <= 1'b0;
            keys_ok_q   <= 1'b0;
            rk_out_q    <= '0;
        end else begin
            state_q     <= state_d;
            r_q         <= r_d;
            kappa_q     <= kappa_d;
            key_ready_q <= key_ready_d;
            busy_q      <= busy_d;
            keys_ok_q   <= keys_ok_d;
            rk_out_q    <= rk_out_d;
        end
    end

    assign key_ready = key_ready_q;
    assign busy      = busy_q;
    assign keys_ok   = keys_ok_q;
    assign rk_out    = rk_out_q;

endmodule
